// File: rtl/line_wr_buffer.sv
// line_wr_buffer: coalescing victim-line write buffer between a cache and memory.
// Holds up to DEPTH {addr, line} entries in a circular FIFO. Victim writes are
// coalesced into the newest matching entry. Reads are forwarded from the buffer
// when they hit, and otherwise go to memory once the FSM is back in IDLE.
module line_wr_buffer #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int DEPTH_LOG     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_LEN-1:0]                  c_addr,
  input  logic                                 c_rd_req,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]     c_rd_line,
  input  logic                                 c_wr_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     c_wr_line,
  output logic                                 c_gnt,
  output logic [ADDR_LEN-1:0]                  m_addr,
  output logic                                 m_rd_req,
  output logic                                 m_wr_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     m_rd_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]     m_wr_line,
  input  logic                                 m_gnt,
  output logic [DEPTH_LOG:0]                   count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int LW    = 32 * (1 << LINE_ADDR_LEN);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   CNT_ONE   = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE   = DEPTH_LOG'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_READ = 2'd2, S_RESP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [ADDR_LEN-1:0]  addr_q [DEPTH];
  logic [ADDR_LEN-1:0]  addr_d [DEPTH];
  logic [LW-1:0]        line_q [DEPTH];
  logic [LW-1:0]        line_d [DEPTH];
  logic                 rd_pend_q, rd_pend_d;
  logic [ADDR_LEN-1:0]  rd_addr_q, rd_addr_d;
  logic                 c_gnt_q, c_gnt_d;
  logic [LW-1:0]        c_rd_line_q, c_rd_line_d;
  logic                 m_rd_req_q, m_rd_req_d, m_wr_req_q, m_wr_req_d;
  logic [ADDR_LEN-1:0]  m_addr_q, m_addr_d;
  logic [LW-1:0]        m_wr_line_q, m_wr_line_d;

  logic                 wr_hit_s, rd_hit_s, accept_s, push_s, pop_s;
  logic [DEPTH_LOG-1:0] wr_idx_s, rd_idx_s;

  // Find the newest entry matching c_addr, walking from oldest to newest; the head is not a coalesce target while it is draining
  always_comb begin
    wr_hit_s = 1'b0;
    wr_idx_s = '0;
    rd_hit_s = 1'b0;
    rd_idx_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [DEPTH_LOG-1:0] idx_v;
      logic                 hit_v;
      logic                 busy_v;
      idx_v    = head_q + DEPTH_LOG'(k);
      hit_v    = ((DEPTH_LOG+1)'(k) < count_q) && (addr_q[idx_v] == c_addr);
      busy_v   = (k == 0) && (state_q == S_DRAIN);
      rd_hit_s = rd_hit_s | hit_v;
      rd_idx_s = hit_v ? idx_v : rd_idx_s;
      wr_hit_s = wr_hit_s | (hit_v & ~busy_v);
      wr_idx_s = (hit_v && !busy_v) ? idx_v : wr_idx_s;
    end
  end

  // Next-state logic: cache-side accept, memory FSM and occupancy update
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    addr_d      = addr_q;
    line_d      = line_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    c_gnt_d     = 1'b0;
    c_rd_line_d = c_rd_line_q;
    m_rd_req_d  = m_rd_req_q;
    m_wr_req_d  = m_wr_req_q;
    m_addr_d    = m_addr_q;
    m_wr_line_d = m_wr_line_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    // A grant cycle, or the cycle that issues the read response, takes no new request
    accept_s    = !c_gnt_q && (state_q != S_RESP);

    if (accept_s && c_wr_req) begin
      if (wr_hit_s) begin
        line_d[wr_idx_s] = c_wr_line;
        c_gnt_d          = 1'b1;
      end else if (count_q < DEPTH_CNT) begin
        addr_d[tail_q] = c_addr;
        line_d[tail_q] = c_wr_line;
        tail_d         = tail_q + PTR_ONE;
        push_s         = 1'b1;
        c_gnt_d        = 1'b1;
      end else begin
        c_gnt_d = 1'b0;
      end
    end else if (accept_s && c_rd_req && !rd_pend_q) begin
      if (rd_hit_s) begin
        c_rd_line_d = line_q[rd_idx_s];
        c_gnt_d     = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = c_addr;
      end
    end else begin
      push_s = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rd_pend_q) begin
          state_d    = S_READ;
          m_rd_req_d = 1'b1;
          m_addr_d   = rd_addr_q;
        end else if (count_q != '0) begin
          // Take the head from the _d view so a same-edge coalesce into it is not lost
          state_d     = S_DRAIN;
          m_wr_req_d  = 1'b1;
          m_addr_d    = addr_d[head_q];
          m_wr_line_d = line_d[head_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (m_gnt) begin
          pop_s      = 1'b1;
          head_d     = head_q + PTR_ONE;
          m_wr_req_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_READ: begin
        if (m_gnt) begin
          c_rd_line_d = m_rd_line;
          m_rd_req_d  = 1'b0;
          state_d     = S_RESP;
        end else begin
          state_d = S_READ;
        end
      end
      S_RESP: begin
        if (!c_gnt_q) begin
          c_gnt_d   = 1'b1;
          rd_pend_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      c_gnt_q     <= 1'b0;
      c_rd_line_q <= '0;
      m_rd_req_q  <= 1'b0;
      m_wr_req_q  <= 1'b0;
      m_addr_q    <= '0;
      m_wr_line_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      c_gnt_q     <= c_gnt_d;
      c_rd_line_q <= c_rd_line_d;
      m_rd_req_q  <= m_rd_req_d;
      m_wr_req_q  <= m_wr_req_d;
      m_addr_q    <= m_addr_d;
      m_wr_line_q <= m_wr_line_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        line_q[i] <= line_d[i];
      end
    end
  end

  assign c_gnt     = c_gnt_q;
  assign c_rd_line = c_rd_line_q;
  assign m_rd_req  = m_rd_req_q;
  assign m_wr_req  = m_wr_req_q;
  assign m_addr    = m_addr_q;
  assign m_wr_line = m_wr_line_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);

endmodule
